// File: rtl/uart_tx.sv
// Transmit serializer for a 16550-style UART: start, 5-8 data bits LSB first, optional parity, 1-2 stop bits.
// Optional UART_TX_BREAK_EN adds tx_break, which forces txd low while the state machine keeps running.
module uart_tx (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    input  logic [3:0] data_bits,
    input  logic       parity_en,
    input  logic       parity_even,
    input  logic [1:0] stop_bits,
    input  logic       tick,
`ifdef UART_TX_BREAK_EN
    input  logic       tx_break,
`endif
    output logic       txd,
    output logic       enable_baud
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t     r_state, w_state_next;
    logic [7:0] r_data, w_data_next;
    logic [2:0] r_last, w_last_next;
    logic       r_par_en, w_par_en_next;
    logic       r_par_even, w_par_even_next;
    logic       r_two_stop, w_two_stop_next;
    logic [2:0] r_idx, w_idx_next;
    logic       r_stop_cnt, w_stop_cnt_next;
    logic       r_line, w_line_next;
    logic       r_busy, w_busy_next;

    logic [7:0] w_mask;
    logic [2:0] w_idx_inc;
    logic [2:0] w_last_clamped;
    logic       w_parity;

    // Only bits inside the latched data length contribute to parity.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_mask
            assign w_mask[gi] = (3'(gi) <= r_last);
        end
    endgenerate

    assign w_parity  = r_par_even ? ^(r_data & w_mask) : ~(^(r_data & w_mask));
    assign w_idx_inc = r_idx + 3'd1;

    // Last bit index; 3-bit wrap maps a length of 8 onto index 7.
    assign w_last_clamped = (data_bits < 4'd5) ? 3'd4 :
                            (data_bits > 4'd8) ? 3'd7 :
                            (data_bits[2:0] - 3'd1);

    always_comb begin
        w_state_next    = r_state;
        w_data_next     = r_data;
        w_last_next     = r_last;
        w_par_en_next   = r_par_en;
        w_par_even_next = r_par_even;
        w_two_stop_next = r_two_stop;
        w_idx_next      = r_idx;
        w_stop_cnt_next = r_stop_cnt;
        w_line_next     = r_line;
        w_busy_next     = r_busy;

        case (r_state)
            IDLE: begin
                w_line_next = 1'b1;
                if (tx_start) begin
                    w_data_next     = tx_data;
                    w_last_next     = w_last_clamped;
                    w_par_en_next   = parity_en;
                    w_par_even_next = parity_even;
                    w_two_stop_next = stop_bits[1];
                    w_idx_next      = 3'd0;
                    w_stop_cnt_next = 1'b0;
                    w_line_next     = 1'b0;
                    w_busy_next     = 1'b1;
                    w_state_next    = START;
                end
            end
            START: begin
                if (tick) begin
                    w_line_next  = r_data[0];
                    w_idx_next   = 3'd0;
                    w_state_next = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (r_idx < r_last) begin
                        w_idx_next  = w_idx_inc;
                        w_line_next = r_data[w_idx_inc];
                    end else if (r_par_en) begin
                        w_line_next  = w_parity;
                        w_state_next = PARITY;
                    end else begin
                        w_line_next     = 1'b1;
                        w_stop_cnt_next = 1'b0;
                        w_state_next    = STOP;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    w_line_next     = 1'b1;
                    w_stop_cnt_next = 1'b0;
                    w_state_next    = STOP;
                end
            end
            STOP: begin
                w_line_next = 1'b1;
                if (tick) begin
                    if (r_stop_cnt || !r_two_stop) begin
                        w_busy_next  = 1'b0;
                        w_state_next = IDLE;
                    end else begin
                        w_stop_cnt_next = 1'b1;
                    end
                end
            end
            default: begin
                w_line_next  = 1'b1;
                w_busy_next  = 1'b0;
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_data     <= 8'd0;
            r_last     <= 3'd0;
            r_par_en   <= 1'b0;
            r_par_even <= 1'b0;
            r_two_stop <= 1'b0;
            r_idx      <= 3'd0;
            r_stop_cnt <= 1'b0;
            r_line     <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_data     <= w_data_next;
            r_last     <= w_last_next;
            r_par_en   <= w_par_en_next;
            r_par_even <= w_par_even_next;
            r_two_stop <= w_two_stop_next;
            r_idx      <= w_idx_next;
            r_stop_cnt <= w_stop_cnt_next;
            r_line     <= w_line_next;
            r_busy     <= w_busy_next;
        end
    end

`ifdef UART_TX_BREAK_EN
    logic r_txd;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_txd <= 1'b1;
        end else begin
            r_txd <= w_line_next & ~tx_break;
        end
    end

    assign txd = r_txd;
`else
    assign txd = r_line;
`endif

    assign tx_busy     = r_busy;
    assign enable_baud = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a table of frames with hand-written per-bit txd values, plus corner-case sequences.
module tb_uart_tx;

    logic       clk;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic [3:0] data_bits;
    logic       parity_en;
    logic       parity_even;
    logic [1:0] stop_bits;
    logic       tick;
    logic       txd;
    logic       enable_baud;
`ifdef UART_TX_BREAK_EN
    logic       tx_break;
`endif

    int checks = 0;
    int errors = 0;

    uart_tx dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .data_bits   (data_bits),
        .parity_en   (parity_en),
        .parity_even (parity_even),
        .stop_bits   (stop_bits),
        .tick        (tick),
`ifdef UART_TX_BREAK_EN
        .tx_break    (tx_break),
`endif
        .txd         (txd),
        .enable_baud (enable_baud)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // seq[0] is the value held during the start bit, seq[j] the value after tick j.
    typedef struct {
        logic [7:0]  data;
        logic [3:0]  bits;
        logic        pen;
        logic        peven;
        logic [1:0]  stop;
        logic [0:11] seq;
        int          len;
    } frame_t;

    frame_t frames [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic run_frame(input int n, input bit inject);
        frame_t f;
        f = frames[n];
        tx_data     = f.data;
        data_bits   = f.bits;
        parity_en   = f.pen;
        parity_even = f.peven;
        stop_bits   = f.stop;
        tx_start    = 1'b1;
        step();
        tx_start    = 1'b0;
        // Scramble the inputs; the frame in flight must use its latched copy.
        tx_data     = ~f.data;
        data_bits   = 4'd6;
        parity_en   = ~f.pen;
        parity_even = ~f.peven;
        stop_bits   = 2'd0;
        $display("frame %0d: data=%h bits=%0d pen=%b peven=%b stop=%0d", n, f.data, f.bits, f.pen, f.peven, f.stop);
        chk($sformatf("f%0d start txd", n), txd, 1'b0);
        chk($sformatf("f%0d start busy", n), tx_busy, 1'b1);
        chk($sformatf("f%0d start enable_baud", n), enable_baud, 1'b1);
        for (int j = 1; j < f.len; j++) begin
            step();
            step();
            chk($sformatf("f%0d hold bit %0d", n, j - 1), txd, f.seq[j-1]);
            pulse_tick();
            chk($sformatf("f%0d bit %0d", n, j), txd, f.seq[j]);
            chk($sformatf("f%0d busy %0d", n, j), tx_busy, 1'b1);
            if (inject && j == 3) begin
                tx_data  = 8'h00;
                tx_start = 1'b1;
                step();
                tx_start = 1'b0;
                chk($sformatf("f%0d restart ignored", n), txd, f.seq[j]);
            end
        end
        step();
        pulse_tick();
        chk($sformatf("f%0d end busy", n), tx_busy, 1'b0);
        chk($sformatf("f%0d end enable_baud", n), enable_baud, 1'b0);
        chk($sformatf("f%0d end txd", n), txd, 1'b1);
    endtask

    initial begin
        frames[0] = '{8'hA5, 4'd8,  1'b0, 1'b0, 2'd1, 12'b010100101100, 10};
        frames[1] = '{8'h3C, 4'd8,  1'b1, 1'b1, 2'd1, 12'b000111100010, 11};
        frames[2] = '{8'h55, 4'd8,  1'b1, 1'b0, 2'd1, 12'b010101010110, 11};
        frames[3] = '{8'h6B, 4'd7,  1'b1, 1'b1, 2'd2, 12'b011010111110, 11};
        frames[4] = '{8'h0F, 4'd6,  1'b0, 1'b0, 2'd1, 12'b011110010000, 8};
        frames[5] = '{8'h1B, 4'd5,  1'b1, 1'b0, 2'd2, 12'b011011111000, 9};
        frames[6] = '{8'hFF, 4'd3,  1'b0, 1'b0, 2'd0, 12'b011111100000, 7};
        frames[7] = '{8'h81, 4'd12, 1'b1, 1'b1, 2'd3, 12'b010000001011, 12};

        rst         = 1'b0;
        tx_data     = 8'h00;
        tx_start    = 1'b0;
        data_bits   = 4'd8;
        parity_en   = 1'b0;
        parity_even = 1'b0;
        stop_bits   = 2'd1;
        tick        = 1'b0;
`ifdef UART_TX_BREAK_EN
        tx_break    = 1'b0;
`endif
        step();
        step();
        chk("reset txd", txd, 1'b1);
        chk("reset busy", tx_busy, 1'b0);
        chk("reset enable_baud", enable_baud, 1'b0);
        rst = 1'b1;
        step();

        // Ticks while idle leave the line at mark.
        for (int k = 0; k < 3; k++) begin
            pulse_tick();
            chk("idle tick txd", txd, 1'b1);
            chk("idle tick busy", tx_busy, 1'b0);
        end

        for (int n = 0; n < 8; n++) begin
            run_frame(n, n == 0);
            step();
        end

        // tx_start coinciding with the final stop tick is dropped.
        frames[4].len = frames[4].len;
        tx_data = 8'h0F; data_bits = 4'd6; parity_en = 1'b0; stop_bits = 2'd1;
        tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        for (int j = 1; j < 8; j++) pulse_tick();
        chk("pre-end busy", tx_busy, 1'b1);
        tick = 1'b1;
        tx_start = 1'b1;
        step();
        tick = 1'b0;
        tx_start = 1'b0;
        chk("start at end busy", tx_busy, 1'b0);
        chk("start at end txd", txd, 1'b1);
        step();
        chk("start at end stays idle", tx_busy, 1'b0);
        tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        chk("next start busy", tx_busy, 1'b1);
        chk("next start txd", txd, 1'b0);
        for (int j = 0; j < 8; j++) pulse_tick();
        chk("next frame done", tx_busy, 1'b0);

        // Reset in DATA while txd is low aborts at once.
        tx_data = 8'hA5; data_bits = 4'd8; parity_en = 1'b0; stop_bits = 2'd1;
        tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        pulse_tick();
        pulse_tick();
        chk("pre-reset txd", txd, 1'b0);
        rst = 1'b0;
        step();
        chk("mid reset txd", txd, 1'b1);
        chk("mid reset busy", tx_busy, 1'b0);
        chk("mid reset enable_baud", enable_baud, 1'b0);
        rst = 1'b1;
        pulse_tick();
        chk("post reset idle txd", txd, 1'b1);

`ifdef UART_TX_BREAK_EN
        tx_break = 1'b1;
        step();
        chk("break idle txd", txd, 1'b0);
        chk("break idle busy", tx_busy, 1'b0);
        tx_break = 1'b0;
        step();
        chk("break release txd", txd, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Transmit serializer of the 16550-compatible UART.
- Converts one parallel character into an asynchronous serial frame on txd: start bit, 5-8 data bits LSB first, optional even/odd parity, then 1 or 2 stop bits.
- Bit timing comes from an external baud generator. This block requests it with enable_baud and advances one bit per tick pulse.
- Sits between the TX holding register/FIFO logic and the serial pin.

Parameters:
- none (frame format is supplied at run time by the line-control inputs)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-low
- tx_data  input  8  character to send; bits above the data length are ignored
- tx_start  input  1  one-cycle request to start a frame
- tx_busy  output  1  high from the frame start until the last stop bit ends
- data_bits  input  4  data length; 5..8 valid
- parity_en  input  1  1 = append a parity bit
- parity_even  input  1  1 = even parity, 0 = odd parity
- stop_bits  input  2  stop-bit count; 1 or 2 valid
- tick  input  1  one-clk-wide pulse, one per bit period, from the baud generator
- txd  output  1  serial output; idle/mark = 1
- enable_baud  output  1  high while a frame is in progress; gates the baud generator

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE, txd=1, tx_busy=0, enable_baud=0, all counters and shadow registers cleared. Reset mid-frame aborts the frame immediately; txd returns to 1 on that same edge.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE: txd=1, tick ignored. When tx_start=1 at a clk edge:
  - latch tx_data, data_bits, parity_en, parity_even, stop_bits into shadow registers;
  - on that same edge set txd=0, tx_busy=1, enable_baud=1 and go to START.
  - Later changes to the inputs do not affect the frame in progress.
- Format clamping at latch time: data_bits below 5 is treated as 5, above 8 as 8; stop_bits 0 is treated as 1, 2 or 3 as 2.
- START: hold txd=0. On tick, drive data bit 0 and go to DATA with bit index 0.
- DATA: on each tick, if the index is below length-1, increment it and drive the next bit (LSB first). At the last bit, go to PARITY if parity is enabled (driving the parity bit), else go to STOP (txd=1).
- Parity bit: XOR of the transmitted data bits only. Even mode sends the XOR, so the total number of ones is even; odd mode sends its inverse. PARITY holds the parity bit; on tick, go to STOP with txd=1.
- STOP: txd=1. On each tick, count stop bits. On the tick ending the final stop bit, go to IDLE with tx_busy=0 and enable_baud=0 on that same edge.
- Exactly one bit advance per clk cycle in which tick=1. No advance without tick.
- Frame length in ticks = 1 + N + P + S.
- tx_start while busy is ignored: not queued, no effect.
- tx_start arriving in the same cycle that the frame returns to IDLE is ignored; a new frame may start from the next cycle onward.
- The first bit period may be shortened, depending on the baud generator's phase when enable_baud rises. That is acceptable.
- All outputs are registered (no combinational path from inputs to txd).

Optional Feature:
- UART_TX_BREAK_EN: adds input port tx_break (1 bit), the 16550 LCR break-control bit.
  - While tx_break=1, txd is forced to 0 regardless of state. The internal state machine keeps running, so busy and tick handling are unchanged.
  - When tx_break returns to 0, txd resumes its normal value.
  - Without the macro: no tx_break port; txd is driven only by the state machine.

Test Plan:
- 0xA5, 8 data bits, no parity, 1 stop -> txd per tick: 0, 1,0,1,0,0,1,0,1, 1. Frame is 10 ticks; tx_busy rises the cycle after tx_start and falls on the 10th tick.
- 0x3C, 8 data bits, even parity, 1 stop -> data bits 0,0,1,1,1,1,0,0, parity 0, stop 1. Frame is 11 ticks.
- 0x55, 8 data bits, odd parity, 1 stop -> data bits 1,0,1,0,1,0,1,0, parity 1. Frame is 11 ticks.
- 0x6B, 7 data bits, even parity, 2 stop -> data bits 1,1,0,1,0,1,1, parity 1, then two stop 1s. Frame is 11 ticks.
- 0x0F with 6 data bits/no parity/1 stop -> data bits 1,1,1,1,0,0, frame 8 ticks. 0x1B with 5 data bits/odd parity/2 stop -> data bits 1,1,0,1,1, parity 1, frame 9 ticks.
- Robustness:
  - a second tx_start pulse mid-frame must be ignored;
  - tick pulses while IDLE must keep txd=1;
  - rst=0 during DATA gives txd=1, tx_busy=0 and enable_baud=0 on the next clk edge.
